// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-cycle sequencer: walks a register mask, transferring one register
// per memory beat between the register file and consecutive memory addresses.
// The pipeline is stalled (busy) while beats are in flight. A one-cycle done
// pulse follows the last beat, with r7_written set if an LM sequence wrote R7.
module lm_sm_sequencer #(
   parameter int  DATA_W = 16,
   parameter int  NREG   = 8,
   localparam int RA_W   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic [NREG-1:0]   reg_mask,
   input  logic [DATA_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              r7_written,
   output logic [RA_W-1:0]   rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              rf_wr_en,
   output logic [RA_W-1:0]   rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // R7 is the program counter; an LM that loads it must be reported upstream.
   localparam logic [RA_W-1:0] PC_IDX = RA_W'(7);

   state_t              state;
   state_t              state_next;
   logic                op_load;
   logic [NREG-1:0]     rem_mask;
   logic [DATA_W-1:0]   ptr;
   logic                r7_flag;

   logic [RA_W-1:0]     idx;
   logic [NREG-1:0]     idx_bit;
   logic [NREG-1:0]     mask_left;

   // Lowest set bit of the remaining mask picks the register for this beat.
   always_comb begin
      idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (rem_mask[i]) idx = RA_W'(i);
      end
      idx_bit   = NREG'(1) << idx;
      mask_left = rem_mask & ~idx_bit;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next state and all outputs; everything idles at zero outside ACCESS.
   always_comb begin
      state_next  = state;
      busy        = 1'b0;
      done        = 1'b0;
      r7_written  = 1'b0;
      rf_rd_addr  = '0;
      rf_wr_en    = 1'b0;
      rf_wr_addr  = '0;
      rf_wr_data  = '0;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      case (state)
         S_IDLE: begin
            if (start) state_next = (reg_mask != '0) ? S_ACCESS : S_DONE;
         end
         S_ACCESS: begin
            busy       = 1'b1;
            mem_addr   = ptr;
            rf_rd_addr = idx;
            rf_wr_addr = idx;
            if (op_load) begin
               mem_rd_en  = 1'b1;
               rf_wr_en   = mem_ready;
               rf_wr_data = mem_rd_data;
            end else begin
               mem_wr_en   = 1'b1;
               mem_wr_data = rf_rd_data;
            end
            if (mem_ready && (mask_left == '0)) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            r7_written = r7_flag;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Sequence context: latched on launch, advanced once per completed beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_load  <= 1'b0;
         rem_mask <= '0;
         ptr      <= '0;
         r7_flag  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_load  <= is_load;
                  rem_mask <= reg_mask;
                  ptr      <= base_addr;
                  r7_flag  <= 1'b0;
               end
            end
            S_ACCESS: begin
               if (mem_ready) begin
                  rem_mask <= mask_left;
                  ptr      <= ptr + DATA_W'(1);
                  if (op_load && (idx == PC_IDX)) r7_flag <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: a set-based model predicts every
// output each cycle, and directed sequences pin latency, data and flags.
module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic [7:0]  reg_mask = 8'h00;
   logic [15:0] base_addr = 16'h0000;
   logic        busy, done, r7_written;
   logic [2:0]  rf_rd_addr, rf_wr_addr;
   logic [15:0] rf_rd_data, rf_wr_data;
   logic        rf_wr_en;
   logic [15:0] mem_addr, mem_wr_data, mem_rd_data;
   logic        mem_rd_en, mem_wr_en;
   logic        mem_ready = 1'b1;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ndone = 0;

   logic [15:0] rf [0:7];
   logic [15:0] mem_w [0:65535];

   lm_sm_sequencer #(.DATA_W(16), .NREG(8)) dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load),
      .reg_mask(reg_mask), .base_addr(base_addr),
      .busy(busy), .done(done), .r7_written(r7_written),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Environment: combinational reg-file read, memory data derived from address.
   assign rf_rd_data  = rf[rf_rd_addr];
   assign mem_rd_data = mem_ready ? (mem_addr ^ 16'h5A5A) : 16'hDEAD;

   initial for (int i = 0; i < 8; i++) rf[i] = 16'hA000 + 16'(i);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rf_wr_en)  rf[rf_wr_addr] <= rf_wr_data;
      if (mem_wr_en) mem_w[mem_addr] <= mem_wr_data;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int low(input logic [7:0] m);
      int r = 0;
      for (int i = 7; i >= 0; i--) if (m[i]) r = i;
      return r;
   endfunction

   // Model: the set of registers still to move, the next address, and a
   // pending completion report.
   logic [7:0]  m_rem = 8'h00;
   logic [15:0] m_addr = 16'h0000;
   logic        m_load = 1'b0;
   logic        m_r7 = 1'b0;
   logic        m_dpend = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem <= 8'h00; m_addr <= 16'h0000; m_load <= 1'b0;
         m_r7 <= 1'b0; m_dpend <= 1'b0;
      end else if (m_dpend) begin
         m_dpend <= 1'b0;
      end else if (m_rem != 8'h00) begin
         if (mem_ready) begin
            m_rem  <= m_rem & ~(8'd1 << low(m_rem));
            m_addr <= m_addr + 16'd1;
            if (m_load && low(m_rem) == 7) m_r7 <= 1'b1;
            if ($countones(m_rem) == 1) m_dpend <= 1'b1;
         end
      end else if (start) begin
         m_load  <= is_load;
         m_rem   <= reg_mask;
         m_addr  <= base_addr;
         m_r7    <= 1'b0;
         m_dpend <= (reg_mask == 8'h00);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic act;
      int   ix;
      logic [15:0] exp_rd;
      act    = (m_rem != 8'h00);
      ix     = act ? low(m_rem) : 0;
      exp_rd = mem_ready ? (m_addr ^ 16'h5A5A) : 16'hDEAD;
      chk("busy",       32'(busy),       32'(act));
      chk("done",       32'(done),       32'(m_dpend));
      chk("r7_written", 32'(r7_written), 32'(m_dpend & m_r7));
      chk("mem_addr",   32'(mem_addr),   act ? 32'(m_addr) : 32'd0);
      chk("mem_rd_en",  32'(mem_rd_en),  32'(act & m_load));
      chk("mem_wr_en",  32'(mem_wr_en),  32'(act & ~m_load));
      chk("rf_rd_addr", 32'(rf_rd_addr), 32'(ix));
      chk("rf_wr_addr", 32'(rf_wr_addr), 32'(ix));
      chk("rf_wr_en",   32'(rf_wr_en),   32'(act & m_load & mem_ready));
      if (!act || m_load)
         chk("rf_wr_data", 32'(rf_wr_data), act ? 32'(exp_rd) : 32'd0);
      if (!act || !m_load)
         chk("mem_wr_data", 32'(mem_wr_data), act ? 32'(rf[ix]) : 32'd0);
      if (done) ndone++;
   end

   task automatic kick(input logic ld, input logic [7:0] mask, input logic [15:0] base,
                       output int t0);
      @(posedge clk); #1;
      start = 1'b1; is_load = ld; reg_mask = mask; base_addr = base;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int t0, input int lat, input logic r7);
      bit seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
      else begin
         chk({nm, "_latency"}, 32'(cyc - t0), 32'(lat));
         chk({nm, "_r7"}, 32'(r7_written), 32'(r7));
      end
   endtask

   initial begin
      int t0;
      int nd0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_rden", 32'(mem_rd_en), 32'd0);
      #10 rst = 1'b0;

      // 1: LM R0,R2 from 0x0100
      kick(1'b1, 8'h05, 16'h0100, t0);
      chk("t1_addr0", 32'(mem_addr), 32'h0100);
      wait_done("t1", t0, 3, 1'b0);
      chk("t1_r0", 32'(rf[0]), 32'h5B5A);
      chk("t1_r2", 32'(rf[2]), 32'h5B5B);

      // 2: SM R0,R7 from 0xFFFF with wrap
      kick(1'b0, 8'h81, 16'hFFFF, t0);
      wait_done("t2", t0, 3, 1'b0);
      chk("t2_mFFFF", 32'(mem_w[16'hFFFF]), 32'h5B5A);
      chk("t2_m0000", 32'(mem_w[16'h0000]), 32'hA007);

      // 3: LM R1 with three wait cycles
      mem_ready = 1'b0;
      kick(1'b1, 8'h02, 16'h0040, t0);
      chk("t3_hold_addr", 32'(mem_addr), 32'h0040);
      chk("t3_hold_wren", 32'(rf_wr_en), 32'd0);
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b1;
      wait_done("t3", t0, 5, 1'b0);
      chk("t3_r1", 32'(rf[1]), 32'h5A1A);

      // 4: empty mask
      kick(1'b1, 8'h00, 16'h1234, t0);
      wait_done("t4", t0, 1, 1'b0);

      // 5a: start pulsed while busy is ignored
      kick(1'b0, 8'h0F, 16'h0200, t0);
      @(posedge clk); #1;
      start = 1'b1; is_load = 1'b1; reg_mask = 8'hF0;
      @(posedge clk); #1 start = 1'b0;
      wait_done("t5a", t0, 5, 1'b0);
      chk("t5a_m0203", 32'(mem_w[16'h0203]), 32'hA003);

      // 5b: reset during second beat
      kick(1'b1, 8'h07, 16'h0300, t0);
      @(posedge clk); #2;
      chk("t5b_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5b_busy", 32'(busy), 32'd0);
      chk("t5b_rden", 32'(mem_rd_en), 32'd0);
      chk("t5b_wren", 32'(rf_wr_en), 32'd0);
      chk("t5b_addr", 32'(mem_addr), 32'd0);
      nd0 = ndone;
      @(posedge clk); #3 rst = 1'b0;
      repeat (4) @(posedge clk);
      chk("t5b_no_done", 32'(ndone), 32'(nd0));
      chk("t5b_r0_kept", 32'(rf[0]), 32'h595A);
      chk("t5b_r1_untouched", 32'(rf[1]), 32'h5A1A);
      kick(1'b1, 8'h03, 16'h0400, t0);
      wait_done("t5c", t0, 3, 1'b0);
      chk("t5c_r1", 32'(rf[1]), 32'h5E5B);

      // 6: R7 flag for LM, not for SM
      kick(1'b1, 8'h80, 16'h0500, t0);
      wait_done("t6a", t0, 2, 1'b1);
      chk("t6a_r7", 32'(rf[7]), 32'h5F5A);
      kick(1'b0, 8'h80, 16'h0600, t0);
      wait_done("t6b", t0, 2, 1'b0);
      chk("t6b_m0600", 32'(mem_w[16'h0600]), 32'h5F5A);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
